// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: op codes, decoder output, FSM states.
// The optional multiplier is enabled by defining ALU_MUL_EN.
package alu_pkg;

    // Internal op codes; branch compares occupy the encodings left free by the arithmetic ops
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SRA  = 4'b0011,
        OP_BEQ  = 4'b0100,
        OP_BNE  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_BGEU = 4'b1011,
        OP_BLT  = 4'b1100,
        OP_BGE  = 4'b1101,
        OP_BLTU = 4'b1110,
        OP_SLTU = 4'b1111
    } alu_opc_e;

    // Decoder output: op code plus a flag selecting the iterative multiplier
    typedef struct packed {
        logic     mul;
        alu_opc_e opc;
    } dec_t;

    localparam logic [1:0] ALU_ADDR  = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_ARITH = 2'b10;

    // The completing edge of a multi-cycle op also raises out_valid, so no
    // separate DONE state is ever held.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef ALU_MUL_EN
        , ST_MUL = 2'd3
`endif
    } state_e;

    function automatic logic is_shift(input alu_opc_e o);
        return o inside {OP_SLL, OP_SRL, OP_SRA};
    endfunction

    function automatic logic is_branch(input alu_opc_e o);
        return o inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

endpackage

// File: rtl/alu_exec_unit_decode.sv
// Pure combinational decode of alu_op/funct3/funct7/is_imm into an internal op code.
// ALU_MUL_EN adds the funct7=0000001 multiply encoding.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_imm,
    output dec_t       dec
);

`ifndef ALU_MUL_EN
    // only funct7[5] selects anything in the base instruction set
    logic unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};
`endif

    // map instruction fields to op code; anything unrecognised falls back to ADD
    always_comb begin
        dec.mul = 1'b0;
        dec.opc = OP_ADD;
        case (alu_op)
            ALU_BR: begin
                case (funct3)
                    3'b001:  dec.opc = OP_BNE;
                    3'b100:  dec.opc = OP_BLT;
                    3'b101:  dec.opc = OP_BGE;
                    3'b110:  dec.opc = OP_BLTU;
                    3'b111:  dec.opc = OP_BGEU;
                    default: dec.opc = OP_BEQ;
                endcase
            end
            ALU_ARITH: begin
`ifdef ALU_MUL_EN
                if (funct7 == 7'b0000001) dec.mul = (funct3 == 3'b000);
                else
`endif
                case (funct3)
                    3'b000:  dec.opc = (!is_imm && funct7[5]) ? OP_SUB : OP_ADD;
                    3'b001:  dec.opc = OP_SLL;
                    3'b010:  dec.opc = OP_SLT;
                    3'b011:  dec.opc = OP_SLTU;
                    3'b100:  dec.opc = OP_XOR;
                    3'b101:  dec.opc = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110:  dec.opc = OP_OR;
                    default: dec.opc = OP_AND;
                endcase
            end
            default: dec.opc = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Decode-and-execute ALU stage with valid/ready handshake. Single-cycle ops
// register their result on the accept edge; shifts step SHIFT_STEP bits per cycle.
// Define ALU_MUL_EN to add an iterative shift-add multiplier (1 bit per cycle).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    state_e          state;
    dec_t            dec;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] single_res;
    logic            single_br;
    logic [XLEN-1:0] sh_val, shift_next;
    logic [CW-1:0]   sh_rem, sh_step;
    alu_opc_e        sh_opc;

    alu_op_decode u_dec (
        .alu_op (alu_op),
        .funct3 (funct3),
        .funct7 (funct7),
        .is_imm (is_imm),
        .dec    (dec)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = operand_b[SHW-1:0];

    // single-cycle result; shift ops only land here when shamt==0, so they pass operand_a
    always_comb begin
        single_res = operand_a + operand_b;
        single_br  = 1'b0;
        case (dec.opc)
            OP_SUB:  single_res = operand_a - operand_b;
            OP_SLT:  single_res = XLEN'($signed(operand_a) < $signed(operand_b));
            OP_SLTU: single_res = XLEN'(operand_a < operand_b);
            OP_XOR:  single_res = operand_a ^ operand_b;
            OP_OR:   single_res = operand_a | operand_b;
            OP_AND:  single_res = operand_a & operand_b;
            OP_SLL, OP_SRL, OP_SRA: single_res = operand_a;
            OP_BEQ:  single_br = (operand_a == operand_b);
            OP_BNE:  single_br = (operand_a != operand_b);
            OP_BLT:  single_br = ($signed(operand_a) <  $signed(operand_b));
            OP_BGE:  single_br = ($signed(operand_a) >= $signed(operand_b));
            OP_BLTU: single_br = (operand_a <  operand_b);
            OP_BGEU: single_br = (operand_a >= operand_b);
            default: single_res = operand_a + operand_b;
        endcase
        if (is_branch(dec.opc)) single_res = XLEN'(single_br);
    end

    // one shift step of at most SHIFT_STEP bits; sh_val keeps the sign bit for SRA
    always_comb begin
        sh_step = (sh_rem < STEP) ? sh_rem : STEP;
        case (sh_opc)
            OP_SLL:  shift_next = sh_val << sh_step;
            OP_SRL:  shift_next = sh_val >> sh_step;
            default: shift_next = $signed(sh_val) >>> sh_step;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mul_acc, mul_mcand, mul_mplier, mul_acc_next;
    logic [CW-1:0]   mul_cnt;

    // add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    end
`else
    logic unused_mul;
    assign unused_mul = dec.mul;
`endif

    // FSM, operand registers and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            sh_val       <= '0;
            sh_rem       <= '0;
            sh_opc       <= OP_ADD;
`ifdef ALU_MUL_EN
            mul_acc      <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            mul_cnt      <= '0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (dec.mul) begin
                            mul_acc    <= '0;
                            mul_mcand  <= operand_a;
                            mul_mplier <= operand_b;
                            mul_cnt    <= CW'(XLEN);
                            state      <= ST_MUL;
                        end else
`endif
                        if (is_shift(dec.opc) && shamt != '0) begin
                            sh_val <= operand_a;
                            sh_rem <= CW'(shamt);
                            sh_opc <= dec.opc;
                            state  <= ST_SHIFT;
                        end else begin
                            result       <= single_res;
                            branch_taken <= single_br;
                            out_valid    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_val <= shift_next;
                    sh_rem <= sh_rem - sh_step;
                    if (sh_rem <= STEP) begin
                        result       <= shift_next;
                        branch_taken <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt - 1'b1;
                    if (mul_cnt == CW'(1)) begin
                        result       <= mul_acc_next;
                        branch_taken <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
